// File: rtl/drop_ctrl.sv
// drop_ctrl: gameplay sequencer for the falling-piece game.
// Times gravity steps, requests collision checks from the board checker,
// issues move/lock/spawn commands and flags game over when a fresh piece
// collides at its spawn position.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_IDLE      | not playing; waits for mode == Game
//   S_SPAWN     | spawn pulse, board loads the next piece
//   S_CHK_SPAWN | checker asked whether the spawn position collides
//   S_WAIT_TICK | counting the gravity interval
//   S_CHK_DOWN  | checker asked whether the piece can drop one row
//   S_MOVE      | move_down pulse
//   S_LOCK      | lock pulse, board writes the piece and clears rows
//   S_LOCK_WAIT | waiting for the board to finish the lock / row clear
//   S_OVER      | game over, held until Reset
module drop_ctrl #(
    parameter int TICK_DIV = 25_000_000,
    parameter int FAST_DIV = 2_500_000,
    parameter int CNT_W    = 25
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] mode,
    input  logic       soft_drop,
    output logic       chk_req,
    output logic       chk_kind,
    input  logic       chk_ack,
    input  logic       chk_hit,
    output logic       move_down,
    output logic       lock,
    input  logic       lock_done,
    input  logic [2:0] lines_cleared,
    output logic       spawn,
    output logic       gameover,
    output logic [7:0] lines_total
);

    localparam logic [1:0]       MODE_GAME = 2'b01;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SPAWN,
        S_CHK_SPAWN,
        S_WAIT_TICK,
        S_CHK_DOWN,
        S_MOVE,
        S_LOCK,
        S_LOCK_WAIT,
        S_OVER
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lines_q, lines_d;

    logic             in_game;
    logic [CNT_W-1:0] cnt_last;
    logic [2:0]       clr_clamp;
    logic [8:0]       lines_sum;
    logic [7:0]       lines_sat;

    assign in_game   = (mode == MODE_GAME);
    // The terminal count follows soft_drop live; the >= compare below means a
    // mid-count switch to the shorter interval fires at once instead of wrapping.
    assign cnt_last  = soft_drop ? FAST_LAST : TICK_LAST;
    assign clr_clamp = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
    assign lines_sum = {1'b0, lines_q} + {6'b0, clr_clamp};
    assign lines_sat = lines_sum[8] ? 8'hFF : lines_sum[7:0];

    // Next-state, tick counter and line total; leaving Game aborts everything but OVER.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lines_d = lines_q;
        if (!in_game && (state_q != S_OVER)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE:      state_d = S_SPAWN;
                S_SPAWN:     state_d = S_CHK_SPAWN;
                S_CHK_SPAWN: begin
                    if (chk_ack) begin
                        state_d = chk_hit ? S_OVER : S_WAIT_TICK;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_TICK: begin
                    if (cnt_q >= cnt_last) begin
                        state_d = S_CHK_DOWN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_CHK_DOWN: begin
                    if (chk_ack) begin
                        state_d = chk_hit ? S_LOCK : S_MOVE;
                    end
                end
                S_MOVE: begin
                    state_d = S_WAIT_TICK;
                    cnt_d   = '0;
                end
                S_LOCK:      state_d = S_LOCK_WAIT;
                S_LOCK_WAIT: begin
                    if (lock_done) begin
                        lines_d = lines_sat;
                        state_d = S_SPAWN;
                    end
                end
                S_OVER:      state_d = S_OVER;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    // State, counter and line total registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
        end
    end

    // Moore outputs straight from the state register.
    assign chk_req     = (state_q == S_CHK_SPAWN) || (state_q == S_CHK_DOWN);
    assign chk_kind    = (state_q == S_CHK_SPAWN);
    assign move_down   = (state_q == S_MOVE);
    assign lock        = (state_q == S_LOCK);
    assign spawn       = (state_q == S_SPAWN);
    assign gameover    = (state_q == S_OVER);
    assign lines_total = lines_q;

endmodule

// File: tb/tb_drop_ctrl.sv
// Directed bench for drop_ctrl with TICK_DIV=8, FAST_DIV=2.
// A small responder answers checks one cycle after chk_req rises and
// returns lock_done the cycle after the lock pulse.
module tb_drop_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] mode;
    logic       soft_drop;
    logic       chk_req, chk_kind, chk_ack, chk_hit;
    logic       move_down, lock, lock_done, spawn, gameover;
    logic [2:0] lines_cleared;
    logic [7:0] lines_total;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic auto_ack = 1'b0;
    logic hit_spawn = 1'b0, hit_down = 1'b0;
    logic spur_ack = 1'b0, spur_done = 1'b0;
    logic req_seen = 1'b0, pend = 1'b0;

    int t0, t1, t2, t3, t4, t5, t6, t7, tl;

    drop_ctrl #(.TICK_DIV(8), .FAST_DIV(2), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .mode(mode), .soft_drop(soft_drop),
        .chk_req(chk_req), .chk_kind(chk_kind), .chk_ack(chk_ack), .chk_hit(chk_hit),
        .move_down(move_down), .lock(lock), .lock_done(lock_done),
        .lines_cleared(lines_cleared), .spawn(spawn), .gameover(gameover),
        .lines_total(lines_total)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Checker / board responder, driven on the falling edge.
    initial begin
        chk_ack = 1'b0; chk_hit = 1'b0; lock_done = 1'b0;
        forever begin
            @(negedge Clk);
            chk_hit   = chk_kind ? hit_spawn : hit_down;
            chk_ack   = (auto_ack && chk_req && req_seen) || spur_ack;
            req_seen  = chk_req;
            lock_done = pend || spur_done;
            pend      = lock;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_move(output int t);
        t = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (move_down) begin
                t = cyc;
                return;
            end
        end
        check_eq("timeout_move", 0, 1);
    endtask

    task automatic wait_lock(output int t);
        t = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (lock) begin
                t = cyc;
                return;
            end
        end
        check_eq("timeout_lock", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; mode = 2'b00; soft_drop = 1'b0; lines_cleared = 3'd0;
        repeat (3) tick();
        check_eq("rst_chk_req", chk_req, 0);
        check_eq("rst_spawn", spawn, 0);
        check_eq("rst_gameover", gameover, 0);
        check_eq("rst_lines", lines_total, 0);
        Reset = 1'b0;
        tick();
        check_eq("idle_spawn", spawn, 0);

        // 1: spawn, spawn check, normal gravity period
        auto_ack = 1'b1;
        mode = 2'b01;
        tick();
        check_eq("t1_spawn_c1", spawn, 1);
        tick();
        check_eq("t1_req_c2", chk_req, 1);
        check_eq("t1_kind_c2", chk_kind, 1);
        tick();
        check_eq("t1_req_c3", chk_req, 1);
        tick();
        check_eq("t1_req_drop", chk_req, 0);
        t0 = cyc;
        repeat (8) tick();
        check_eq("t1_req_after_tick", chk_req, 1);
        check_eq("t1_kind_down", chk_kind, 0);
        wait_move(t1);
        check_eq("t1_first_move", t1 - t0, 10);
        tick();
        check_eq("t1_move_width", move_down, 0);
        wait_move(t2);
        check_eq("t1_period", t2 - t1, 11);

        // 2: soft drop fast period, late press at counter 5, release
        soft_drop = 1'b1;
        wait_move(t3);
        check_eq("t2_fast_period", t3 - t2, 5);
        wait_move(t4);
        check_eq("t2_fast_period2", t4 - t3, 5);
        soft_drop = 1'b0;
        repeat (6) tick();
        soft_drop = 1'b1;
        wait_move(t5);
        check_eq("t2_press_mid", t5 - t4, 9);
        soft_drop = 1'b0;
        wait_move(t6);
        check_eq("t2_release", t6 - t5, 11);

        // 6: spurious ack / lock_done while waiting for the tick
        tick();
        spur_ack = 1'b1; spur_done = 1'b1;
        repeat (3) begin
            tick();
            check_eq("t6_no_pulse", {move_down, lock, spawn}, 0);
        end
        spur_ack = 1'b0; spur_done = 1'b0;
        wait_move(t7);
        check_eq("t6_period", t7 - t6, 11);

        // 3: lock path, clamp and saturation of lines_total
        hit_down = 1'b1; lines_cleared = 3'd3;
        wait_lock(tl);
        tick();
        check_eq("t3_lock_width", lock, 0);
        check_eq("t3_lines_pre", lines_total, 0);
        tick();
        check_eq("t3_spawn", spawn, 1);
        check_eq("t3_lines3", lines_total, 3);
        lines_cleared = 3'd7;
        wait_lock(tl);
        repeat (2) tick();
        check_eq("t3_clamp", lines_total, 7);
        lines_cleared = 3'd3;
        for (int i = 0; i < 82; i++) wait_lock(tl);
        repeat (2) tick();
        check_eq("t3_lines253", lines_total, 253);
        for (int i = 0; i < 5; i++) wait_lock(tl);

        // 4: collision at spawn -> gameover
        hit_spawn = 1'b1;
        repeat (2) tick();
        check_eq("t3_sat_spawn", spawn, 1);
        check_eq("t3_sat", lines_total, 255);
        repeat (2) tick();
        check_eq("t4_req_ack_cycle", chk_req, 1);
        check_eq("t4_go_before", gameover, 0);
        tick();
        check_eq("t4_gameover", gameover, 1);
        check_eq("t4_req_off", chk_req, 0);
        mode = 2'b10;
        repeat (3) tick();
        check_eq("t4_go_sticky", gameover, 1);
        check_eq("t4_lines_kept", lines_total, 255);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_eq("t4_go_reset", gameover, 0);
        check_eq("t4_lines_reset", lines_total, 0);
        hit_spawn = 1'b0; hit_down = 1'b0;

        // 5: abort while chk_req high, late ack ignored, fresh spawn
        auto_ack = 1'b0;
        mode = 2'b01;
        tick();
        check_eq("t5_spawn", spawn, 1);
        tick();
        check_eq("t5_req", chk_req, 1);
        mode = 2'b00;
        tick();
        check_eq("t5_abort_req", chk_req, 0);
        spur_ack = 1'b1;
        repeat (2) tick();
        spur_ack = 1'b0;
        check_eq("t5_idle_outs", {chk_req, move_down, lock, spawn, gameover}, 0);
        mode = 2'b01;
        tick();
        check_eq("t5_respawn", spawn, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
